multiword_add_seq: RTL and testbench

//  Sequencer sitting directly upstream/downstream of the 16-bit lookahead adder.
//  - Accepts WORDS*16-bit add/subtract operations over a valid/ready handshake.
//  - Feeds the adder one 16-bit slice per cycle, LSW first, chaining the carry through a register.
//  - Consumes each slice sum and carry-out, then presents the full result with carry and signed overflow.

---
 rtl/multiword_add_seq.sv | 152 +++++++++++++++
 tb/tb_multiword_add_seq.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/multiword_add_seq.sv
`default_nettype none
`timescale 1ns/1ps
// +----------------------------------------------------------------------------+
// | Module : multiword_add_seq                                                 |
// | Brief  : Streams WORDS*16-bit add/sub through an external 16-bit adder,    |
// |          one slice per cycle LSW first, and returns sum, carry, overflow.  |
// | Rev    : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
module multiword_add_seq #(
  parameter int WORDS = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [WORDS*16-1:0] in_a,
  input  logic [WORDS*16-1:0] in_b,
  input  logic                in_sub,
  output logic [15:0]         add_a,
  output logic [15:0]         add_b,
  output logic                add_cin,
  input  logic [15:0]         add_s,
  input  logic                add_cout,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [WORDS*16-1:0] out_sum,
  output logic                out_cout,
  output logic                out_ovf
);

  localparam int W  = WORDS * 16;
  localparam int CW = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WORDS - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          carry_q, carry_d;
  logic          sub_q, sub_d;
  logic [W-1:0]  a_q, a_d;
  logic [W-1:0]  b_q, b_d;
  logic [W-1:0]  sum_q, sum_d;
  logic          cout_q, cout_d;
  logic          ovf_q, ovf_d;

  logic [W-1:0]  a_shift;
  logic [W-1:0]  b_shift;

  // Selecting the active slice by shifting keeps the index math within cnt width.
  assign a_shift = a_q >> {cnt_q, 4'b0000};
  assign b_shift = b_q >> {cnt_q, 4'b0000};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      carry_q <= 1'b0;
      sub_q   <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      sub_q   <= sub_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    sub_d   = sub_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          a_d     = in_a;
          b_d     = in_b;
          sub_d   = in_sub;
          cnt_d   = '0;
          carry_d = in_sub;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        for (int i = 0; i < WORDS; i++) begin
          if (cnt_q == CW'(i)) begin
            sum_d[i*16 +: 16] = add_s;
          end
        end
        carry_d = add_cout;
        if (cnt_q == CNT_LAST) begin
          // On the top slice add_a/add_b carry the operand sign bits (B already inverted for sub).
          cout_d  = add_cout;
          ovf_d   = (add_a[15] == add_b[15]) && (add_s[15] != add_a[15]);
          cnt_d   = '0;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_DONE: begin
        if (out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_comb begin
    in_ready  = (state_q == S_IDLE);
    out_valid = (state_q == S_DONE);
    out_sum   = sum_q;
    out_cout  = cout_q;
    out_ovf   = ovf_q;
    add_a     = 16'd0;
    add_b     = 16'd0;
    add_cin   = 1'b0;
    if (state_q == S_RUN) begin
      add_a   = a_shift[15:0];
      add_b   = b_shift[15:0] ^ {16{sub_q}};
      add_cin = carry_q;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_multiword_add_seq.sv
`default_nettype none
`timescale 1ns/1ps
// +----------------------------------------------------------------------------+
// | Module : tb_multiword_add_seq                                              |
// | Brief  : Directed bench for the WORDS=4 and WORDS=1 sequencer variants.    |
// | Rev    : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
module tb_multiword_add_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        in_valid, in_ready, in_sub, out_valid, out_ready, out_cout, out_ovf;
  logic [63:0] in_a, in_b, out_sum;
  logic [15:0] add_a, add_b, add_s;
  logic        add_cin, add_cout;

  logic        in_valid1, in_ready1, in_sub1, out_valid1, out_ready1, out_cout1, out_ovf1;
  logic [15:0] in_a1, in_b1, out_sum1;
  logic [15:0] add_a1, add_b1, add_s1;
  logic        add_cin1, add_cout1;

  // Behavioural stand-ins for the 16-bit lookahead adder.
  assign {add_cout, add_s}   = {1'b0, add_a} + {1'b0, add_b} + {16'd0, add_cin};
  assign {add_cout1, add_s1} = {1'b0, add_a1} + {1'b0, add_b1} + {16'd0, add_cin1};

  multiword_add_seq #(.WORDS(4)) dut4 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b), .in_sub(in_sub),
    .add_a(add_a), .add_b(add_b), .add_cin(add_cin), .add_s(add_s), .add_cout(add_cout),
    .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum),
    .out_cout(out_cout), .out_ovf(out_ovf)
  );

  multiword_add_seq #(.WORDS(1)) dut1 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid1), .in_ready(in_ready1), .in_a(in_a1), .in_b(in_b1), .in_sub(in_sub1),
    .add_a(add_a1), .add_b(add_b1), .add_cin(add_cin1), .add_s(add_s1), .add_cout(add_cout1),
    .out_valid(out_valid1), .out_ready(out_ready1), .out_sum(out_sum1),
    .out_cout(out_cout1), .out_ovf(out_ovf1)
  );

  typedef struct {
    logic [63:0] a;
    logic [63:0] b;
    logic        sub;
    logic [63:0] sum;
    logic        cout;
    logic        ovf;
  } vec_t;

  localparam int NV = 8;
  vec_t vecs [NV];

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Issue one op on the WORDS=4 DUT from a negedge; returns cycles until out_valid.
  task automatic run_op4(input logic [63:0] a, input logic [63:0] b, input logic s,
                         output int lat);
    int k;
    k = 0;
    while (!in_ready && k < 30) begin
      @(negedge clk);
      k++;
    end
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    in_sub   = s;
    @(negedge clk);
    in_valid = 1'b0;
    in_a     = ~a;
    in_b     = ~b;
    in_sub   = ~s;
    lat      = 1;
    while (!out_valid && lat < 30) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic release4(input string name);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check({name, "_valid_drop"}, {63'd0, out_valid}, 64'd0);
    check({name, "_ready_back"}, {63'd0, in_ready}, 64'd1);
  endtask

  task automatic run_op1(input logic [15:0] a, input logic [15:0] b, input logic s,
                         output int lat);
    int k;
    k = 0;
    while (!in_ready1 && k < 30) begin
      @(negedge clk);
      k++;
    end
    in_valid1 = 1'b1;
    in_a1     = a;
    in_b1     = b;
    in_sub1   = s;
    @(negedge clk);
    in_valid1 = 1'b0;
    in_a1     = ~a;
    in_b1     = ~b;
    lat       = 1;
    while (!out_valid1 && lat < 30) begin
      @(negedge clk);
      lat++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int     lat;
    int     acc [$];
    int     cyc;
    string  nm;
    logic [63:0] held_sum;

    vecs[0] = '{64'h0000_0000_0000_FFFF, 64'h1, 1'b0, 64'h0000_0000_0001_0000, 1'b0, 1'b0};
    vecs[1] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 64'h0, 1'b1, 1'b0};
    vecs[2] = '{64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 64'h8000_0000_0000_0000, 1'b0, 1'b1};
    vecs[3] = '{64'h5, 64'h7, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0};
    vecs[4] = '{64'h7, 64'h5, 1'b1, 64'h2, 1'b1, 1'b0};
    vecs[5] = '{64'h8000_0000_0000_0000, 64'h1, 1'b1, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1};
    vecs[6] = '{64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b0,
                64'h2222_2222_2222_2211, 1'b0, 1'b0};
    vecs[7] = '{64'h0, 64'h0, 1'b1, 64'h0, 1'b1, 1'b0};

    rst_n = 1'b0;
    in_valid = 1'b0; in_a = '0; in_b = '0; in_sub = 1'b0; out_ready = 1'b0;
    in_valid1 = 1'b0; in_a1 = '0; in_b1 = '0; in_sub1 = 1'b0; out_ready1 = 1'b0;
    #1;
    check("rst_in_ready",  {63'd0, in_ready}, 64'd1);
    check("rst_out_valid", {63'd0, out_valid}, 64'd0);
    check("rst_out_sum",   out_sum, 64'd0);
    check("rst_flags",     {62'd0, out_cout, out_ovf}, 64'd0);
    check("rst_adder",     {31'd0, add_a, add_b, add_cin}, 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < NV; i++) begin
      run_op4(vecs[i].a, vecs[i].b, vecs[i].sub, lat);
      nm = $sformatf("vec%0d", i);
      check({nm, "_latency"}, 64'(lat), 64'd5);
      check({nm, "_sum"},  out_sum, vecs[i].sum);
      check({nm, "_cout"}, {63'd0, out_cout}, {63'd0, vecs[i].cout});
      check({nm, "_ovf"},  {63'd0, out_ovf},  {63'd0, vecs[i].ovf});
      release4(nm);
    end

    // Back-pressure: result held, new requests ignored while out_ready stays low.
    run_op4(64'h0001_0002_0003_0004, 64'h0010_0020_0030_0040, 1'b0, lat);
    check("hold_first_sum", out_sum, 64'h0011_0022_0033_0044);
    held_sum = 64'h0011_0022_0033_0044;
    for (int j = 0; j < 10; j++) begin
      in_valid = j[0];
      in_a     = 64'hDEAD_BEEF_0000_0000 + 64'(j);
      in_b     = 64'h1;
      @(negedge clk);
      check($sformatf("hold%0d_valid", j), {63'd0, out_valid}, 64'd1);
      check($sformatf("hold%0d_ready", j), {63'd0, in_ready}, 64'd0);
      check($sformatf("hold%0d_sum", j), out_sum, held_sum);
    end
    in_valid = 1'b0;
    release4("hold");
    run_op4(64'd3, 64'd4, 1'b0, lat);
    check("hold_next_latency", 64'(lat), 64'd5);
    check("hold_next_sum", out_sum, 64'd7);
    release4("hold_next");

    // Asynchronous reset in the middle of RUN (cnt==2).
    in_valid = 1'b1;
    in_a = 64'h1111_2222_3333_4444;
    in_b = 64'h1;
    in_sub = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("mid_slice2_add_a", {48'd0, add_a}, 64'h2222);
    #2 rst_n = 1'b0;
    #1;
    check("arst_in_ready",  {63'd0, in_ready}, 64'd1);
    check("arst_out_valid", {63'd0, out_valid}, 64'd0);
    check("arst_out_sum",   out_sum, 64'd0);
    check("arst_adder",     {31'd0, add_a, add_b, add_cin}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("arst_release_ready", {63'd0, in_ready}, 64'd1);
    run_op4(64'h1234, 64'h1, 1'b0, lat);
    check("arst_next_latency", 64'(lat), 64'd5);
    check("arst_next_sum", out_sum, 64'h1235);
    release4("arst_next");

    // Single-slice variant.
    run_op1(16'h8000, 16'h8000, 1'b0, lat);
    check("w1_latency", 64'(lat), 64'd2);
    check("w1_sum",  {48'd0, out_sum1}, 64'd0);
    check("w1_cout", {63'd0, out_cout1}, 64'd1);
    check("w1_ovf",  {63'd0, out_ovf1}, 64'd1);
    out_ready1 = 1'b1;
    @(negedge clk);
    check("w1_ready_back", {63'd0, in_ready1}, 64'd1);

    in_valid1 = 1'b1;
    in_a1 = 16'h0001;
    in_b1 = 16'h0002;
    in_sub1 = 1'b0;
    cyc = 0;
    for (int j = 0; j < 12; j++) begin
      if (in_ready1) acc.push_back(cyc);
      @(negedge clk);
      cyc++;
    end
    in_valid1 = 1'b0;
    check("w1_b2b_accepts", 64'(acc.size() >= 3), 64'd1);
    if (acc.size() >= 3) begin
      check("w1_b2b_gap0", 64'(acc[1] - acc[0]), 64'd3);
      check("w1_b2b_gap1", 64'(acc[2] - acc[1]), 64'd3);
    end
    check("w1_b2b_sum", {48'd0, out_sum1}, 64'd3);
    out_ready1 = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
